// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values and coin acceptor state encoding.
// Imported by the coin acceptor front end and by the vending FSM.
package vend_pkg;

    localparam logic [4:0] COIN_NONE = 5'd0;
    localparam logic [4:0] COIN_5    = 5'd5;
    localparam logic [4:0] COIN_10   = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        JAM
    } acc_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a hold-time debounce filter.
// Both edges of filt lag the raw input by the same amount.
module sensor_debounce #(
    parameter int DBNC_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = (DBNC_CYC > 1) ? $clog2(DBNC_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DBNC_CYC - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s_sync;

    assign s_sync = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // filt only follows after the new level held for DBNC_CYC samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (s_sync == filt) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            filt <= s_sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the beam sensor, measures blocked width and
// classifies each coin as 5 or 10 cents, a reject, or a jam.
import vend_pkg::*;

module coin_acceptor #(
    parameter int DBNC_CYC   = 4,
    parameter int NICKEL_MIN = 20,
    parameter int NICKEL_MAX = 40,
    parameter int DIME_MIN   = 50,
    parameter int DIME_MAX   = 80,
    parameter int JAM_CYC    = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw,
    input  logic       accept_en,
    output logic [4:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam logic [CNT_W-1:0] N_MIN = CNT_W'(NICKEL_MIN);
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NICKEL_MAX);
    localparam logic [CNT_W-1:0] D_MIN = CNT_W'(DIME_MIN);
    localparam logic [CNT_W-1:0] D_MAX = CNT_W'(DIME_MAX);
    localparam logic [CNT_W-1:0] J_CYC = CNT_W'(JAM_CYC);

    acc_state_t       state, state_nxt;
    logic [CNT_W-1:0] wcnt, wcnt_nxt;
    logic             acc_q, acc_nxt;
    logic [4:0]       coin_nxt;
    logic             reject_nxt;
    logic             filt;

    sensor_debounce #(
        .DBNC_CYC(DBNC_CYC)
    ) u_dbnc (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sensor_raw),
        .filt (filt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= '0;
            acc_q  <= 1'b0;
            coin   <= COIN_NONE;
            reject <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            acc_q  <= acc_nxt;
            coin   <= coin_nxt;
            reject <= reject_nxt;
        end
    end

    // IDLE is only ever entered with filt low, so filt high there is a rising edge
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        acc_nxt    = acc_q;
        coin_nxt   = COIN_NONE;
        reject_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (filt) begin
                    state_nxt = MEASURE;
                    wcnt_nxt  = CNT_W'(1);
                    acc_nxt   = accept_en;
                end
            end
            MEASURE: begin
                if (filt) begin
                    wcnt_nxt = wcnt + 1'b1;
                    if (wcnt_nxt == J_CYC) begin
                        state_nxt = JAM;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (acc_q && wcnt >= N_MIN && wcnt <= N_MAX) begin
                        coin_nxt = COIN_5;
                    end else if (acc_q && wcnt >= D_MIN && wcnt <= D_MAX) begin
                        coin_nxt = COIN_10;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            JAM: begin
                if (!filt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign jam  = (state == JAM);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised scoreboard bench for coin_acceptor: expected coin results are
// queued from pulse widths and checked by an independent output monitor.
module tb_coin_acceptor;

    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic       accept_en = 1'b0;
    logic [4:0] coin;
    logic       reject;
    logic       jam;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [4:0] val;
        logic       rej;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    coin_acceptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor_raw(sensor_raw),
        .accept_en (accept_en),
        .coin      (coin),
        .reject    (reject),
        .jam       (jam),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference classification straight from the width/enable rules
    function automatic exp_t predict(int w, bit acc, int fall);
        exp_t e;
        e.at  = fall + LAT;
        e.val = 5'd0;
        e.rej = 1'b0;
        if (acc && w >= 20 && w <= 40)      e.val = 5'd5;
        else if (acc && w >= 50 && w <= 80) e.val = 5'd10;
        else                                e.rej = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (coin != 5'd0 || reject) begin
            if (coin != 5'd0 && reject) check("coin_and_reject", 1, 0);
            if (sb.size() == 0) begin
                check("unexpected_coin", int'(coin), 0);
                check("unexpected_reject", int'(reject), 0);
            end else begin
                m_e = sb.pop_front();
                check("coin_value", int'(coin), int'(m_e.val));
                check("reject_value", int'(reject), int'(m_e.rej));
                check("output_cycle", cyc, m_e.at);
            end
        end else if (sb.size() > 0 && sb[0].at < cyc) begin
            m_e = sb.pop_front();
            check("missing_output_cycle", cyc, m_e.at);
        end
    end

    task automatic hold(bit v, int n);
        sensor_raw = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entry value of accept_en held long enough for the FSM to sample it
    task automatic pulse(int w, bit acc, bit wiggle, int gap);
        accept_en = acc;
        sensor_raw = 1'b1;
        for (int i = 1; i <= w; i++) begin
            @(posedge clk);
            #1;
            if (wiggle && i >= 8) accept_en = 1'($urandom_range(0, 1));
        end
        sensor_raw = 1'b0;
        sb.push_back(predict(w, acc, cyc));
        for (int j = 1; j <= gap; j++) begin
            @(posedge clk);
            #1;
            if (wiggle && w + j >= 8) accept_en = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_coin"}, int'(coin), 0);
        check({tag, "_reject"}, int'(reject), 0);
        check({tag, "_jam"}, int'(jam), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    int widths[12] = '{30, 50, 60, 80, 20, 40, 45, 19, 21, 39, 49, 81};
    int edge_w[8]  = '{19, 20, 40, 41, 49, 50, 80, 81};

    initial begin
        int start;
        int w;
        rst_n = 1'b0;
        hold(0, 3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        hold(0, 10);
        check_idle_outputs("post_reset");

        foreach (widths[i]) pulse(widths[i], 1'b1, 1'b0, 15);
        pulse(60, 1'b0, 1'b0, 15);
        pulse(60, 1'b1, 1'b1, 15);
        pulse(30, 1'b0, 1'b1, 15);

        // glitches must never reach the FSM
        repeat (3) begin
            hold(1, 2);
            hold(0, 10);
        end
        check_idle_outputs("glitch");

        // bounced nickel: stable high run to stable low run is 32 cycles
        accept_en = 1'b1;
        hold(1, 1);
        hold(0, 1);
        hold(1, 30);
        hold(0, 1);
        hold(1, 1);
        sb.push_back(predict(32, 1'b1, cyc));
        hold(0, 20);

        // stuck sensor
        accept_en = 1'b1;
        start = cyc;
        hold(1, 260);
        check("jam_before_255", int'(jam), 0);
        check("busy_measuring", int'(busy), 1);
        hold(1, 1);
        check("jam_at_255", int'(jam), 1);
        check("busy_jammed", int'(busy), 1);
        hold(1, 300 - (cyc - start));
        check("jam_held", int'(jam), 1);
        hold(0, 20);
        check_idle_outputs("jam_release");

        // reset in mid-coin; the remainder is a fresh 30-cycle nickel
        accept_en = 1'b1;
        hold(1, 31);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_coin_reset");
        hold(1, 3);
        rst_n = 1'b1;
        hold(1, 30);
        sb.push_back(predict(30, 1'b1, cyc));
        hold(0, 20);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) w = edge_w[$urandom_range(0, 7)];
            else w = int'($urandom_range(4, 120));
            pulse(w, 1'($urandom_range(0, 3) != 0), 1'b1,
                  int'($urandom_range(6, 30)));
        end

        hold(0, 20);
        check("scoreboard_empty", sb.size(), 0);
        check_idle_outputs("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
